// File: rtl/mtl_vid_pkg.sv
// mtl_vid_pkg: shared types and default widths for the MTL2/VGA video receiver.
package mtl_vid_pkg;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_CNT_W  = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DROP
  } rxState_t;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [DEF_DATA_W-1:0] data;
  } fifoEntry_t;

endpackage

// File: rtl/mtl_vid_rx_fifo.sv
// mtl_vid_rx_fifo: synchronous show-ahead FIFO. The head entry is always visible
// on o_data; a push into a full FIFO is accepted only when a pop happens in the
// same cycle.
module mtl_vid_rx_fifo
  import mtl_vid_pkg::*;
#(
  parameter int W     = DEF_DATA_W + 2,
  parameter int DEPTH = 16
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wrPtr;
  logic [AW:0]  r_rdPtr;
  logic         w_pushOk;
  logic         w_popOk;

  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_popOk  = i_pop && !o_empty;
  assign w_pushOk = i_push && (!o_full || w_popOk);
  assign o_data   = r_mem[r_rdPtr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_popOk)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge i_clk) begin
    if (w_pushOk) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/mtl_vid_rx.sv
// mtl_vid_rx: clocked-video receiver. Frames active pixels into an Avalon-ST
// stream (sop/eop) through a show-ahead FIFO and flags FIFO overflow.
// Optional feature macro MTL_VID_RX_STATS_EN: adds frame geometry measurement
// (active_width/active_height) and lock detection; otherwise those outputs are 0.
module mtl_vid_rx
  import mtl_vid_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              i_vid_clk,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_vid_data,
  input  logic              i_vid_datavalid,
  input  logic              i_vid_h_sync,
  input  logic              i_vid_v_sync,
  output logic [DATA_W-1:0] o_dout_data,
  output logic              o_dout_valid,
  input  logic              i_dout_ready,
  output logic              o_dout_sop,
  output logic              o_dout_eop,
  output logic [CNT_W-1:0]  o_active_width,
  output logic [CNT_W-1:0]  o_active_height,
  output logic              o_locked,
  output logic              o_overflow,
  input  logic              i_clear_overflow
);

  localparam int ENTRY_W = DATA_W + 2;

  rxState_t            r_state;
  rxState_t            w_nextState;
  logic                r_vsPrev;
  logic                r_holdValid;
  logic                r_holdSop;
  logic [DATA_W-1:0]   r_holdData;
  logic                r_firstPending;
  logic                r_overflow;
  logic                w_vsEdge;
  logic                w_pixel;
  logic                w_push;
  logic                w_pushEop;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_overflowEvt;
  logic [ENTRY_W-1:0]  w_pushEntry;
  logic [ENTRY_W-1:0]  w_head;
  logic                w_unusedHsync;

  // Line structure comes from datavalid runs, so H sync carries no extra information
  assign w_unusedHsync = i_vid_h_sync;

  assign w_vsEdge    = i_vid_v_sync && !r_vsPrev;
  assign w_pixel     = i_vid_datavalid && !i_vid_v_sync;
  assign w_pushEntry = {r_holdSop, w_pushEop, r_holdData};
  assign w_pop       = !w_empty && i_dout_ready;

  assign o_dout_valid = !w_empty;
  assign o_dout_data  = w_empty ? '0 : w_head[DATA_W-1:0];
  assign o_dout_sop   = !w_empty && w_head[DATA_W+1];
  assign o_dout_eop   = !w_empty && w_head[DATA_W];
  assign o_overflow   = r_overflow;

  // Previous V sync sample for frame-boundary edge detection
  always_ff @(posedge i_vid_clk) begin
    if (!i_reset_n) r_vsPrev <= 1'b0;
    else            r_vsPrev <= i_vid_v_sync;
  end

  // State register
  always_ff @(posedge i_vid_clk) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_nextState;
  end

  // Next state and FIFO push: the held pixel goes out when the next one arrives or, tagged eop, at the VS edge
  always_comb begin
    w_nextState = r_state;
    w_push      = 1'b0;
    w_pushEop   = 1'b0;
    if (r_state == ST_ACTIVE) begin
      if (w_vsEdge) begin
        w_push    = r_holdValid;
        w_pushEop = 1'b1;
      end else if (w_pixel && r_holdValid) begin
        w_push = 1'b1;
      end
    end
    w_overflowEvt = w_push && w_full && !w_pop;
    if (w_vsEdge)           w_nextState = ST_ACTIVE;
    else if (w_overflowEvt) w_nextState = ST_DROP;
  end

  // One-entry hold register; emptied at every frame boundary and whenever not receiving
  always_ff @(posedge i_vid_clk) begin
    if (!i_reset_n) begin
      r_holdValid    <= 1'b0;
      r_holdSop      <= 1'b0;
      r_holdData     <= '0;
      r_firstPending <= 1'b0;
    end else if (w_vsEdge) begin
      r_holdValid    <= 1'b0;
      r_firstPending <= 1'b1;
    end else if (r_state == ST_ACTIVE && !w_overflowEvt) begin
      if (w_pixel) begin
        r_holdValid    <= 1'b1;
        r_holdData     <= i_vid_data;
        r_holdSop      <= r_firstPending;
        r_firstPending <= 1'b0;
      end
    end else begin
      r_holdValid <= 1'b0;
    end
  end

  // Sticky overflow flag; a clear wins over a same-cycle overflow
  always_ff @(posedge i_vid_clk) begin
    if (!i_reset_n)             r_overflow <= 1'b0;
    else if (i_clear_overflow)  r_overflow <= 1'b0;
    else if (w_overflowEvt)     r_overflow <= 1'b1;
  end

  mtl_vid_rx_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_vid_clk),
    .i_reset_n (i_reset_n),
    .i_push    (w_push),
    .i_data    (w_pushEntry),
    .i_pop     (w_pop),
    .o_data    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

`ifdef MTL_VID_RX_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_prevPix;
  logic [CNT_W-1:0] r_pixCnt;
  logic [CNT_W-1:0] r_lineCnt;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_height;
  logic [CNT_W-1:0] r_matchCnt;
  logic             r_locked;
  logic             w_runStart;
  logic             w_geomMatch;
  logic [CNT_W-1:0] w_matchNext;

  assign w_runStart  = w_pixel && !r_prevPix;
  assign w_geomMatch = (r_pixCnt == r_width) && (r_lineCnt == r_height) &&
                       (r_pixCnt != '0) && (r_lineCnt != '0);
  assign w_matchNext = !w_geomMatch ? '0 :
                       (r_matchCnt == CNT_MAX) ? r_matchCnt : r_matchCnt + CNT_W'(1);

  assign o_active_width  = r_width;
  assign o_active_height = r_height;
  assign o_locked        = r_locked;

  // Saturating run-length and line counters, restarted at each frame boundary
  always_ff @(posedge i_vid_clk) begin
    if (!i_reset_n) begin
      r_prevPix <= 1'b0;
      r_pixCnt  <= '0;
      r_lineCnt <= '0;
    end else begin
      r_prevPix <= w_pixel;
      if (w_vsEdge) begin
        r_pixCnt  <= '0;
        r_lineCnt <= '0;
      end else if (w_pixel) begin
        if (w_runStart) begin
          r_pixCnt <= CNT_W'(1);
          if (r_lineCnt != CNT_MAX) r_lineCnt <= r_lineCnt + CNT_W'(1);
        end else if (r_pixCnt != CNT_MAX) begin
          r_pixCnt <= r_pixCnt + CNT_W'(1);
        end
      end
    end
  end

  // Latch geometry at the frame boundary and track how many frames in a row matched
  always_ff @(posedge i_vid_clk) begin
    if (!i_reset_n) begin
      r_width    <= '0;
      r_height   <= '0;
      r_matchCnt <= '0;
      r_locked   <= 1'b0;
    end else if (w_vsEdge) begin
      r_width    <= r_pixCnt;
      r_height   <= r_lineCnt;
      r_matchCnt <= w_matchNext;
      r_locked   <= (w_matchNext >= CNT_W'(LOCK_FRAMES));
    end
  end
`else
  logic w_unusedLock;

  // Lock threshold only matters when measurement is built in
  assign w_unusedLock    = (LOCK_FRAMES == 0);
  assign o_active_width  = '0;
  assign o_active_height = '0;
  assign o_locked        = 1'b0;
`endif

endmodule

// File: tb/tb_mtl_vid_rx.sv
// tb_mtl_vid_rx: directed self-checking bench for mtl_vid_rx.
module tb_mtl_vid_rx;

`ifdef MTL_VID_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] vidData;
  logic        vidDv;
  logic        vidHs;
  logic        vidVs;
  logic [23:0] doutData;
  logic        doutValid;
  logic        doutReady;
  logic        doutSop;
  logic        doutEop;
  logic [11:0] activeWidth;
  logic [11:0] activeHeight;
  logic        locked;
  logic        overflow;
  logic        clearOverflow;

  int          vectors = 0;
  int          miscompares = 0;
  logic [25:0] beatQ [$];

  always #5 clk = ~clk;

  mtl_vid_rx dut (
    .i_vid_clk        (clk),
    .i_reset_n        (reset_n),
    .i_vid_data       (vidData),
    .i_vid_datavalid  (vidDv),
    .i_vid_h_sync     (vidHs),
    .i_vid_v_sync     (vidVs),
    .o_dout_data      (doutData),
    .o_dout_valid     (doutValid),
    .i_dout_ready     (doutReady),
    .o_dout_sop       (doutSop),
    .o_dout_eop       (doutEop),
    .o_active_width   (activeWidth),
    .o_active_height  (activeHeight),
    .o_locked         (locked),
    .o_overflow       (overflow),
    .i_clear_overflow (clearOverflow)
  );

  // Record every beat the sink accepts, sampled mid-cycle
  always @(negedge clk) begin
    if (reset_n === 1'b1 && doutValid === 1'b1 && doutReady === 1'b1)
      beatQ.push_back({doutSop, doutEop, doutData});
  end

  task automatic applyStimulus(input logic dv, input logic hs, input logic vs, input logic [23:0] d);
    vidDv   = dv;
    vidHs   = hs;
    vidVs   = vs;
    vidData = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic sendBlank(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, (i == 0), 1'b0, 24'h0);
  endtask

  task automatic sendLine(input int n, input logic [23:0] base);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, base + 24'(i));
  endtask

  task automatic sendFrame(input int w, input int h, input logic [23:0] base);
    for (int l = 0; l < h; l++) begin
      sendLine(w, base + 24'(l * w));
      sendBlank(2);
    end
  endtask

  task automatic vsPulse(input logic dvHigh);
    applyStimulus(dvHigh, 1'b0, 1'b1, 24'hBAD);
    applyStimulus(dvHigh, 1'b0, 1'b1, 24'hBAD);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  function automatic logic [25:0] mkBeat(input logic sop, input logic eop, input logic [23:0] d);
    return {sop, eop, d};
  endfunction

  function automatic logic [25:0] getBeat(input int i);
    if (i < beatQ.size()) return beatQ[i];
    return '1;
  endfunction

  function automatic logic [31:0] stat(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  initial begin
    reset_n       = 1'b0;
    doutReady     = 1'b1;
    clearOverflow = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);

    // Reset state
    checkOutput("rst_valid",  32'(doutValid),    32'd0);
    checkOutput("rst_sop",    32'(doutSop),      32'd0);
    checkOutput("rst_eop",    32'(doutEop),      32'd0);
    checkOutput("rst_data",   32'(doutData),     32'd0);
    checkOutput("rst_locked", 32'(locked),       32'd0);
    checkOutput("rst_ovf",    32'(overflow),     32'd0);
    checkOutput("rst_width",  32'(activeWidth),  32'd0);
    checkOutput("rst_height", 32'(activeHeight), 32'd0);
    reset_n = 1'b1;

    // 4x3 frame, pixels 1..12
    $display("[TB] 4x3 frame");
    beatQ.delete();
    vsPulse(1'b0);
    sendFrame(4, 3, 24'h000001);
    vsPulse(1'b0);
    sendBlank(4);
    checkOutput("f1_count", 32'(beatQ.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      checkOutput($sformatf("f1_beat%0d", i), 32'(getBeat(i)), 32'(mkBeat(i == 0, i == 11, 24'(i + 1))));
    checkOutput("f1_width",  32'(activeWidth),  stat(4));
    checkOutput("f1_height", 32'(activeHeight), stat(3));
    checkOutput("f1_locked", 32'(locked),       32'd0);

    // Repeat the frame: one match is not enough, two are
    sendFrame(4, 3, 24'h000001);
    vsPulse(1'b0);
    checkOutput("f2_locked", 32'(locked), 32'd0);
    sendFrame(4, 3, 24'h000001);
    vsPulse(1'b0);
    checkOutput("f3_locked", 32'(locked), stat(1));
    sendFrame(5, 3, 24'h000020);
    vsPulse(1'b0);
    checkOutput("f5x3_locked", 32'(locked),       32'd0);
    checkOutput("f5x3_width",  32'(activeWidth),  stat(5));
    checkOutput("f5x3_height", 32'(activeHeight), stat(3));
    sendBlank(4);

    // Full FIFO: last pixel pushed on the same cycle the sink pops
    $display("[TB] push at full with pop");
    doutReady = 1'b0;
    sendBlank(2);
    beatQ.delete();
    vsPulse(1'b0);
    sendLine(17, 24'h000300);
    doutReady = 1'b1;
    vsPulse(1'b0);
    sendBlank(24);
    checkOutput("full_ovf",   32'(overflow),     32'd0);
    checkOutput("full_count", 32'(beatQ.size()), 32'd17);
    for (int i = 0; i < 17; i++)
      checkOutput($sformatf("full_beat%0d", i), 32'(getBeat(i)),
                  32'(mkBeat(i == 0, i == 16, 24'h000300 + 24'(i))));

    // Overflow: 40-pixel frame into a stalled sink
    $display("[TB] overflow");
    doutReady = 1'b0;
    beatQ.delete();
    vsPulse(1'b0);
    sendFrame(8, 5, 24'h000100);
    vsPulse(1'b0);
    checkOutput("ovf_set",      32'(overflow),  32'd1);
    checkOutput("ovf_headsop",  32'(doutSop),   32'd1);
    checkOutput("ovf_headdata", 32'(doutData),  32'h100);
    doutReady = 1'b1;
    sendFrame(4, 3, 24'h000200);
    vsPulse(1'b0);
    sendBlank(8);
    checkOutput("ovf_count", 32'(beatQ.size()), 32'd28);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("ovf_kept%0d", i), 32'(getBeat(i)),
                  32'(mkBeat(i == 0, 1'b0, 24'h000100 + 24'(i))));
    for (int i = 0; i < 12; i++)
      checkOutput($sformatf("ovf_next%0d", i), 32'(getBeat(16 + i)),
                  32'(mkBeat(i == 0, i == 11, 24'h000200 + 24'(i))));
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
    clearOverflow = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    clearOverflow = 1'b0;
    checkOutput("ovf_clear", 32'(overflow), 32'd0);

    // Reset in the middle of a frame
    $display("[TB] mid-frame reset");
    doutReady = 1'b0;
    vsPulse(1'b0);
    sendLine(4, 24'h000400);
    checkOutput("mrst_pre_valid", 32'(doutValid), 32'd1);
    reset_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 24'h000404);
    reset_n = 1'b1;
    checkOutput("mrst_valid",  32'(doutValid), 32'd0);
    checkOutput("mrst_locked", 32'(locked),    32'd0);
    sendLine(3, 24'h000410);
    sendBlank(2);
    checkOutput("mrst_discard", 32'(doutValid), 32'd0);
    doutReady = 1'b1;
    beatQ.delete();
    vsPulse(1'b0);
    sendFrame(2, 2, 24'h000420);
    vsPulse(1'b0);
    sendBlank(6);
    checkOutput("mrst_count", 32'(beatQ.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("mrst_beat%0d", i), 32'(getBeat(i)),
                  32'(mkBeat(i == 0, i == 3, 24'h000420 + 24'(i))));

    // Datavalid during V sync is ignored; single-pixel frame
    $display("[TB] single-pixel frame");
    beatQ.delete();
    vsPulse(1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 24'h000555);
    sendBlank(2);
    vsPulse(1'b1);
    sendBlank(4);
    checkOutput("one_count",  32'(beatQ.size()), 32'd1);
    checkOutput("one_beat",   32'(getBeat(0)),   32'(mkBeat(1'b1, 1'b1, 24'h000555)));
    checkOutput("one_width",  32'(activeWidth),  stat(1));
    checkOutput("one_height", 32'(activeHeight), stat(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
